cga_capture: RTL and testbench

Pixel-stream capture sink at the far end of the CGA RGBI pixel path: samples the 4-bit `pix_in` stream with its hsync/vsync, locates the active window by sync edges, packs four pixels per 16-bit word, and hands addressed words to a framebuffer writer over a valid/ready interface. Used for frame grabbing, on-chip scan conversion and the regression compare path. The design is single-clock; pixels arrive on a dot-clock enable.

---
 rtl/cga_capture_pkg.sv | 26 ++
 rtl/cga_capture_fifo.sv | 64 ++++++
 rtl/cga_capture.sv | 199 +++++++++++++++++++
 tb/tb_cga_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_capture_pkg.sv
// Shared types and constants for the CGA RGBI capture sink.
package cga_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_ACTIVE     = 2'd2
   } state_e;

   localparam int unsigned PIX_PER_WORD = 4;
   localparam int unsigned PIX_W        = 4;
   localparam int unsigned WORD_W       = 16;
   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned CNT_W        = 12;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } cap_word_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cga_capture_fifo.sv
// First-word-fall-through FIFO; head_c always shows the oldest entry.
module cga_capture_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_c,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO still lands when a pop frees the slot this cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_c  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_o   <= 1'b0;
         empty_o  <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         full_o  <= (count_d == (AW+1)'(DEPTH));
         empty_o <= (count_d == '0);
      end
   end

endmodule

// File: rtl/cga_capture.sv
// CGA RGBI capture sink: windows the pixel stream by sync edges, packs four
// pixels per word and queues addressed words for a framebuffer writer.
module cga_capture
   import cga_capture_pkg::*;
#(
   parameter int unsigned H_OFFSET   = 48,
   parameter int unsigned V_OFFSET   = 16,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pix_en,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              enable,
   output logic [WORD_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_done,
   output logic              frame_err,
   output logic              overflow,
   input  logic              clear_overflow,
   output logic              busy
);

   localparam logic [CNT_W-1:0]  H_FIRST = CNT_W'(H_OFFSET);
   localparam logic [CNT_W-1:0]  H_END   = CNT_W'(H_OFFSET + H_ACTIVE);
   localparam logic [CNT_W-1:0]  H_LAST  = CNT_W'(H_OFFSET + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  V_FIRST = CNT_W'(V_OFFSET);
   localparam logic [CNT_W-1:0]  V_END   = CNT_W'(V_OFFSET + V_ACTIVE);
   localparam logic [CNT_W-1:0]  V_LAST  = CNT_W'(V_OFFSET + V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] WPL     = ADDR_W'(H_ACTIVE / PIX_PER_WORD);

   state_e            state_q;
   logic              hsync_q;
   logic              vsync_q;
   logic [CNT_W-1:0]  h_cnt_q;
   logic [CNT_W-1:0]  v_cnt_q;
   logic [1:0]        slot_q;
   logic [ADDR_W-1:0] word_col_q;
   logic [ADDR_W-1:0] row_base_q;
   logic [WORD_W-1:0] pack_q;

   logic              hs_fall;
   logic              vs_fall;
   logic              restart;
   logic [CNT_W-1:0]  h_cur;
   logic [CNT_W-1:0]  v_cur;
   logic [1:0]        slot_cur;
   logic [ADDR_W-1:0] col_cur;
   logic [ADDR_W-1:0] row_cur;
   logic              in_win;
   logic              capture;
   logic              push;
   logic              last_word;
   logic              pop;
   logic              ovf_set;
   logic [WORD_W-1:0] pack_d;
   cap_word_t         push_word;
   cap_word_t         head;
   logic              fifo_full;
   logic              fifo_empty;

   // The dot carrying an hsync falling edge is dot 0 of the new line, so all
   // per-line state is viewed through its post-edge value on that dot.
   always_comb begin
      hs_fall   = pix_en && hsync_q && !hsync;
      vs_fall   = pix_en && vsync_q && !vsync;
      restart   = vs_fall && (state_q != ST_IDLE);
      h_cur     = hs_fall ? '0 : h_cnt_q;
      v_cur     = hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
      slot_cur  = hs_fall ? 2'd0 : slot_q;
      col_cur   = hs_fall ? '0 : word_col_q;
      row_cur   = row_base_q;
      if (hs_fall && (v_cnt_q >= V_FIRST) && (v_cnt_q < V_END)) begin
         row_cur = row_base_q + WPL;
      end
      in_win    = (h_cur >= H_FIRST) && (h_cur < H_END) &&
                  (v_cur >= V_FIRST) && (v_cur < V_END);
      capture   = pix_en && (state_q == ST_ACTIVE) && !vs_fall && in_win;
      pack_d    = pack_q;
      pack_d[{slot_cur, 2'b00} +: PIX_W] = pix_in;
      push      = capture && (slot_cur == 2'd3);
      push_word.addr = row_cur + col_cur;
      push_word.data = pack_d;
      last_word = push && (h_cur == H_LAST) && (v_cur == V_LAST);
      pop       = out_ready && !fifo_empty;
      ovf_set   = push && fifo_full && !pop;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         slot_q     <= '0;
         word_col_q <= '0;
         row_base_q <= '0;
         pack_q     <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (pix_en) begin
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            h_cnt_q    <= sat_inc(h_cur);
            v_cnt_q    <= v_cur;
            slot_q     <= slot_cur;
            word_col_q <= col_cur;
            row_base_q <= row_cur;
         end

         if (capture) begin
            pack_q <= pack_d;
            slot_q <= slot_cur + 2'd1;
            if (push) begin
               word_col_q <= col_cur + ADDR_W'(1);
            end
         end

         // Dropped words still advance addressing; only the flag records it.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end

         // A vsync edge (re)starts the frame and throws away any partial word.
         if (restart) begin
            v_cnt_q    <= '0;
            row_base_q <= '0;
            slot_q     <= '0;
            word_col_q <= '0;
            pack_q     <= '0;
         end

         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q <= ST_WAIT_FRAME;
                  busy    <= 1'b1;
               end
            end
            ST_WAIT_FRAME: begin
               if (vs_fall) begin
                  state_q <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (vs_fall) begin
                  frame_err <= 1'b1;
               end else if (last_word) begin
                  frame_done <= 1'b1;
                  if (enable) begin
                     state_q <= ST_WAIT_FRAME;
                  end else begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   cga_capture_fifo #(
      .WIDTH ($bits(cap_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .data_i  (push_word),
      .pop_i   (out_ready),
      .head_c  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = head.data;
   assign out_addr  = head.addr;

endmodule

// File: tb/tb_cga_capture.sv
// Scoreboard bench for cga_capture: two instances differing only in V_ACTIVE.
module tb_cga_capture;

   localparam int unsigned HO       = 2;
   localparam int unsigned VO       = 1;
   localparam int unsigned HA       = 8;
   localparam int unsigned VA_A     = 2;
   localparam int unsigned VA_B     = 6;
   localparam int          LINE_LEN = 14;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pix_en = 1'b0;
   logic [3:0]  pix_in = 4'h0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic        enable = 1'b0;
   logic        out_ready = 1'b0;
   logic        clear_overflow = 1'b0;

   logic [15:0] a_data, a_addr, b_data, b_addr;
   logic        a_valid, a_fd, a_fe, a_ovf, a_busy;
   logic        b_valid, b_fd, b_fe, b_ovf, b_busy;

   logic        sel = 1'b0;
   logic [15:0] m_data, m_addr;
   logic        m_valid, m_fd, m_fe, m_ovf, m_busy;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   fd_cnt = 0;
   int   fe_cnt = 0;
   bit   abort = 1'b0;
   bit   seen;

   always #5 clk = ~clk;

   cga_capture #(.H_OFFSET(HO), .V_OFFSET(VO), .H_ACTIVE(HA), .V_ACTIVE(VA_A),
                 .FIFO_DEPTH(8)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .pix_in(pix_in),
      .hsync(hsync), .vsync(vsync), .enable(enable),
      .out_data(a_data), .out_addr(a_addr), .out_valid(a_valid),
      .out_ready(out_ready), .frame_done(a_fd), .frame_err(a_fe),
      .overflow(a_ovf), .clear_overflow(clear_overflow), .busy(a_busy));

   cga_capture #(.H_OFFSET(HO), .V_OFFSET(VO), .H_ACTIVE(HA), .V_ACTIVE(VA_B),
                 .FIFO_DEPTH(8)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .pix_in(pix_in),
      .hsync(hsync), .vsync(vsync), .enable(enable),
      .out_data(b_data), .out_addr(b_addr), .out_valid(b_valid),
      .out_ready(out_ready), .frame_done(b_fd), .frame_err(b_fe),
      .overflow(b_ovf), .clear_overflow(clear_overflow), .busy(b_busy));

   assign m_data  = sel ? b_data  : a_data;
   assign m_addr  = sel ? b_addr  : a_addr;
   assign m_valid = sel ? b_valid : a_valid;
   assign m_fd    = sel ? b_fd    : a_fd;
   assign m_fe    = sel ? b_fe    : a_fe;
   assign m_ovf   = sel ? b_ovf   : a_ovf;
   assign m_busy  = sel ? b_busy  : a_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every accepted word is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (m_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: actual addr 0x%0h data 0x%0h, required none",
                     m_addr, m_data);
         end else begin
            e = exp_q.pop_front();
            chk("word_addr", 32'(m_addr), 32'(e.addr));
            chk("word_data", 32'(m_data), 32'(e.data));
         end
      end
      if (m_fd) fd_cnt++;
      if (m_fe) fe_cnt++;
   end

   // Every captured line of this geometry carries pixels 2..9 = h count.
   task automatic exp_word(input int addr);
      exp_t e;
      e.addr = 16'(addr);
      e.data = (addr % 2 == 0) ? 16'h5432 : 16'h9876;
      exp_q.push_back(e);
   endtask

   task automatic dot(input bit hs, input bit vs, input logic [3:0] px);
      @(posedge clk); #1;
      pix_en = 1'b1; hsync = hs; vsync = vs; pix_in = px;
      @(posedge clk); #1;
      pix_en = 1'b0;
   endtask

   // hsync high on the last dot, so the next line's dot 0 is the falling edge.
   task automatic line(input int len, input bit vline);
      for (int d = 0; d < len; d++) begin
         if (abort) return;
         dot(d == len - 1, vline && (d == 0), 4'(d));
      end
   endtask

   task automatic frame(input int nlines);
      line(LINE_LEN, 1'b1);
      for (int i = 0; i < nlines; i++) line(LINE_LEN, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; clear_overflow = 1'b0;
      abort = 1'b0;
      exp_q.delete();
      fd_cnt = 0;
      fe_cnt = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_sig(input int which, output bit found);
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((which == 0 && m_ovf) || (which == 1 && m_fd)) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      sel = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data",  32'(m_data),  0);
      chk("rst_addr",  32'(m_addr),  0);
      chk("rst_done",  32'(m_fd),    0);
      chk("rst_err",   32'(m_fe),    0);
      chk("rst_ovf",   32'(m_ovf),   0);
      chk("rst_busy",  32'(m_busy),  0);

      // 1: small frame
      do_reset();
      out_ready = 1'b1; enable = 1'b1;
      for (int a = 0; a < 4; a++) exp_word(a);
      frame(3);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t1_queue_left", exp_q.size(), 0);
      chk("t1_done_count", fd_cnt, 1);
      chk("t1_err_count", fe_cnt, 0);
      chk("t1_busy", 32'(m_busy), 1);

      // 2: overflow on the 9th word of a 12-word frame
      sel = 1'b1;
      do_reset();
      out_ready = 1'b0; enable = 1'b1;
      for (int a = 0; a < 8; a++) exp_word(a);
      for (int a = 9; a < 12; a++) exp_word(a);
      fork
         frame(7);
         begin
            wait_sig(0, seen);
            chk("t2_overflow_set", 32'(seen), 1);
            chk("t2_head_addr", 32'(m_addr), 0);
            out_ready = 1'b1;
         end
      join
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("t2_queue_left", exp_q.size(), 0);
      chk("t2_done_count", fd_cnt, 1);
      chk("t2_overflow_sticky", 32'(m_ovf), 1);
      @(posedge clk); #1 clear_overflow = 1'b1;
      @(posedge clk); #1 clear_overflow = 1'b0;
      @(negedge clk);
      chk("t2_overflow_clear", 32'(m_ovf), 0);

      // 3: premature vsync after one captured line
      sel = 1'b0;
      do_reset();
      out_ready = 1'b1; enable = 1'b1;
      exp_word(0); exp_word(1);
      for (int a = 0; a < 4; a++) exp_word(a);
      line(LINE_LEN, 1'b1);
      line(LINE_LEN, 1'b0);
      line(LINE_LEN, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t3_err_count", fe_cnt, 1);
      chk("t3_no_done", fd_cnt, 0);
      for (int i = 0; i < 3; i++) line(LINE_LEN, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t3_queue_left", exp_q.size(), 0);
      chk("t3_done_count", fd_cnt, 1);
      chk("t3_err_total", fe_cnt, 1);

      // 4: short first line (5 pixels captured)
      do_reset();
      out_ready = 1'b1; enable = 1'b1;
      exp_word(0); exp_word(2); exp_word(3);
      line(LINE_LEN, 1'b1);
      line(7, 1'b0);
      for (int i = 0; i < 3; i++) line(LINE_LEN, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t4_queue_left", exp_q.size(), 0);
      chk("t4_done_count", fd_cnt, 1);

      // 5: enable dropped mid-frame
      do_reset();
      out_ready = 1'b1; enable = 1'b1;
      for (int a = 0; a < 4; a++) exp_word(a);
      line(LINE_LEN, 1'b1);
      line(LINE_LEN, 1'b0);
      enable = 1'b0;
      @(negedge clk);
      chk("t5_busy_mid", 32'(m_busy), 1);
      fork
         begin
            line(LINE_LEN, 1'b0);
            line(LINE_LEN, 1'b0);
         end
         begin
            wait_sig(1, seen);
            chk("t5_done_seen", 32'(seen), 1);
            @(negedge clk);
            chk("t5_busy_low", 32'(m_busy), 0);
         end
      join
      frame(3);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t5_queue_left", exp_q.size(), 0);
      chk("t5_done_count", fd_cnt, 1);
      chk("t5_busy_idle", 32'(m_busy), 0);

      // 6: reset while words are waiting
      sel = 1'b1;
      do_reset();
      out_ready = 1'b0; enable = 1'b1;
      fork
         frame(7);
         begin
            wait_sig(0, seen);
            chk("t6_overflow_set", 32'(seen), 1);
            chk("t6_valid_before", 32'(m_valid), 1);
            #2 reset_n = 1'b0;
            #1;
            chk("t6_valid_rst", 32'(m_valid), 0);
            chk("t6_busy_rst", 32'(m_busy), 0);
            chk("t6_ovf_rst", 32'(m_ovf), 0);
            abort = 1'b1;
         end
      join
      repeat (2) @(posedge clk);
      #1;
      hsync = 1'b0; vsync = 1'b0; pix_en = 1'b0;
      abort = 1'b0; fd_cnt = 0; fe_cnt = 0;
      reset_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) line(LINE_LEN, 1'b0);
      @(negedge clk);
      chk("t6_busy_wait", 32'(m_busy), 1);
      chk("t6_done_none", fd_cnt, 0);
      for (int a = 0; a < 12; a++) exp_word(a);
      frame(7);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("t6_queue_left", exp_q.size(), 0);
      chk("t6_done_count", fd_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
